gray_cmd_arb: RTL and testbench

Round-robin command arbiter that shares the single 4-bit command input of the one-hot sequencer FSM among several requesters. It accepts one command per transaction through a valid/ready handshake and drives it onto the FSM command bus. It holds the command until the FSM output shows a completed excursion (left the idle code, then returned to it), then releases the bus. A timeout recovers the bus if the FSM never returns to idle.

---
 rtl/gray_cmd_arb.sv | 115 +++++++++++
 tb/tb_gray_cmd_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_cmd_arb.sv
// Round-robin arbiter sharing the one-hot sequencer's command input among NREQ requesters.
// Holds a granted command until the FSM leaves idle and comes back, or until a timeout fires.
module gray_cmd_arb #(
  parameter int                NREQ      = 4,
  parameter int                CMD_W     = 4,
  parameter int                OUT_W     = 8,
  parameter logic [OUT_W-1:0]  IDLE_CODE = {{(OUT_W-1){1'b0}}, 1'b1},
  parameter logic [CMD_W-1:0]  IDLE_CMD  = '0,
  parameter int                TIMEOUT   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*CMD_W-1:0]    req_cmd,
  output logic [NREQ-1:0]          req_ready,
  output logic [CMD_W-1:0]         fsm_cmd,
  input  logic [OUT_W-1:0]         fsm_out,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic                     tmo
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state;
  logic [IW-1:0]    ptr;
  logic             left;
  logic [TW-1:0]    timer;

  logic [IW-1:0]    win;
  logic             any;
  logic [NREQ-1:0]  win_oh;
  logic [CMD_W-1:0] win_cmd;
  logic             at_idle;
  logic             complete;
  logic             expired;

  // Scan offsets from far to near so the nearest valid index after ptr is the last write.
  always_comb begin
    win = ptr;
    any = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[IW'((int'(ptr) + k) % NREQ)]) begin
        win = IW'((int'(ptr) + k) % NREQ);
        any = 1'b1;
      end
    end
  end

  always_comb begin
    win_cmd = IDLE_CMD;
    for (int k = 0; k < NREQ; k++) begin
      if (win == IW'(k)) win_cmd = req_cmd[k*CMD_W +: CMD_W];
    end
  end

  assign win_oh    = {{(NREQ-1){1'b0}}, 1'b1} << win;
  assign req_ready = (state == S_IDLE && any) ? win_oh : '0;

  assign at_idle  = (fsm_out == IDLE_CODE);
  assign complete = left && at_idle;
  assign expired  = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      fsm_cmd <= IDLE_CMD;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tmo     <= 1'b0;
      done_id <= '0;
      ptr     <= IW'(NREQ - 1);
      left    <= 1'b0;
      timer   <= '0;
    end else begin
      done <= 1'b0;
      tmo  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any) begin
            state   <= S_RUN;
            fsm_cmd <= win_cmd;
            grant   <= win_oh;
            busy    <= 1'b1;
            ptr     <= win;
            left    <= 1'b0;
            timer   <= '0;
          end
        end
        S_RUN: begin
          timer <= timer + 1'b1;
          if (!at_idle) left <= 1'b1;
          // Completion takes precedence when it coincides with the last timeout cycle.
          if (complete || expired) begin
            state   <= S_IDLE;
            fsm_cmd <= IDLE_CMD;
            grant   <= '0;
            busy    <= 1'b0;
            done_id <= ptr;
            done    <= complete;
            tmo     <= !complete;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_cmd_arb.sv
// Bench for gray_cmd_arb: directed vector table, hand-written timeout/tie/reset sequences,
// then random traffic against a transaction-level reference model.
module tb_gray_cmd_arb;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_cmd;
  logic [3:0]  req_ready;
  logic [3:0]  fsm_cmd;
  logic [7:0]  fsm_out;
  logic [3:0]  grant;
  logic        busy, done, tmo;
  logic [1:0]  done_id;

  int total = 0;
  int bad   = 0;

  gray_cmd_arb #(
    .NREQ(4), .CMD_W(4), .OUT_W(8), .IDLE_CODE(8'h01), .IDLE_CMD(4'h0), .TIMEOUT(32)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
    .fsm_cmd(fsm_cmd), .fsm_out(fsm_out), .grant(grant), .busy(busy), .done(done),
    .done_id(done_id), .tmo(tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [15:0] cmd;
    logic [7:0]  out;
    logic [3:0]  rdy;
    logic [3:0]  gnt;
    logic [3:0]  fcmd;
    logic        b;
    logic        d;
    logic        t;
    logic [1:0]  id;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [3:0] rdy, input logic [3:0] gnt,
                            input logic [3:0] fcmd, input logic b, input logic d,
                            input logic t, input logic [1:0] id);
    chk({tag, " req_ready"}, 32'(req_ready), 32'(rdy));
    chk({tag, " grant"},     32'(grant),     32'(gnt));
    chk({tag, " fsm_cmd"},   32'(fsm_cmd),   32'(fcmd));
    chk({tag, " busy"},      32'(busy),      32'(b));
    chk({tag, " done"},      32'(done),      32'(d));
    chk({tag, " tmo"},       32'(tmo),       32'(t));
    chk({tag, " done_id"},   32'(done_id),   32'(id));
  endtask

  task automatic drive(input logic [3:0] v, input logic [15:0] c, input logic [7:0] o);
    req_valid = v;
    req_cmd   = c;
    fsm_out   = o;
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model state: owner index (-1 when the bus is free) and last-served index.
  int         m_owner, m_last, m_runcyc, m_id;
  bit         m_left, m_done, m_tmo;
  logic [3:0] m_cmd;

  function automatic int pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  initial begin
    tbl[0]  = '{4'b0001, 16'h0001, 8'h01, 4'b0001, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{4'b0000, 16'h0001, 8'h02, 4'b0000, 4'b0001, 4'h1, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{4'b0000, 16'h0001, 8'h01, 4'b0000, 4'b0001, 4'h1, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[3]  = '{4'b0000, 16'h0001, 8'h01, 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[4]  = '{4'b0000, 16'h0001, 8'h01, 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[5]  = '{4'b1111, 16'h4321, 8'h01, 4'b0010, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0};
    tbl[6]  = '{4'b1111, 16'h4321, 8'h04, 4'b0000, 4'b0010, 4'h2, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[7]  = '{4'b1111, 16'h4321, 8'h01, 4'b0000, 4'b0010, 4'h2, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[8]  = '{4'b1111, 16'h4321, 8'h01, 4'b0100, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[9]  = '{4'b1111, 16'h4321, 8'h08, 4'b0000, 4'b0100, 4'h3, 1'b1, 1'b0, 1'b0, 2'd1};
    tbl[10] = '{4'b1111, 16'h4321, 8'h01, 4'b0000, 4'b0100, 4'h3, 1'b1, 1'b0, 1'b0, 2'd1};
    tbl[11] = '{4'b1111, 16'h4321, 8'h01, 4'b1000, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 2'd2};
    tbl[12] = '{4'b1111, 16'h4321, 8'h00, 4'b0000, 4'b1000, 4'h4, 1'b1, 1'b0, 1'b0, 2'd2};
    tbl[13] = '{4'b1111, 16'h4321, 8'h01, 4'b0000, 4'b1000, 4'h4, 1'b1, 1'b0, 1'b0, 2'd2};
    tbl[14] = '{4'b1111, 16'h4321, 8'h01, 4'b0001, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 2'd3};
    tbl[15] = '{4'b1111, 16'h4321, 8'h02, 4'b0000, 4'b0001, 4'h1, 1'b1, 1'b0, 1'b0, 2'd3};
    tbl[16] = '{4'b1111, 16'h4321, 8'h01, 4'b0000, 4'b0001, 4'h1, 1'b1, 1'b0, 1'b0, 2'd3};
    tbl[17] = '{4'b0000, 16'h4321, 8'h01, 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0};
    tbl[18] = '{4'b0000, 16'h4321, 8'h01, 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0};

    rst = 1'b1;
    drive(4'b0000, 16'h0000, 8'h01);
    step;
    step;
    expect_all("reset", 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].vld, tbl[i].cmd, tbl[i].out);
      expect_all($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].gnt, tbl[i].fcmd,
                 tbl[i].b, tbl[i].d, tbl[i].t, tbl[i].id);
      step;
    end

    // Timeout with fsm_out stuck away from idle; requester 2 owns the bus.
    drive(4'b0100, 16'h0A00, 8'h01);
    expect_all("tmo_accept", 4'b0100, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    step;
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(4'b0000, 16'h0A00, 8'h10);
      chk($sformatf("tmo_run%0d busy", i), 32'(busy), 32'd1);
      chk($sformatf("tmo_run%0d tmo", i), 32'(tmo), 32'd0);
      step;
    end
    drive(4'b0011, 16'h0005, 8'h01);
    expect_all("tmo_pulse", 4'b0001, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b1, 2'd2);
    step;

    // Never-left: fsm_out parked at idle for the whole RUN; requester 0 owns the bus.
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(4'b0000, 16'h0005, 8'h01);
      chk($sformatf("nl_run%0d done", i), 32'(done), 32'd0);
      chk($sformatf("nl_run%0d grant", i), 32'(grant), 32'b0001);
      chk($sformatf("nl_run%0d tmo", i), 32'(tmo), 32'd0);
      step;
    end
    drive(4'b0000, 16'h0005, 8'h01);
    expect_all("nl_pulse", 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b1, 2'd0);
    step;

    // Tie: return to idle on exactly the last timeout cycle.
    drive(4'b0010, 16'h0060, 8'h01);
    expect_all("tie_accept", 4'b0010, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    step;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      drive(4'b0000, 16'h0060, 8'h02);
      chk($sformatf("tie_run%0d tmo", i), 32'(tmo), 32'd0);
      step;
    end
    drive(4'b0000, 16'h0060, 8'h01);
    chk("tie_last busy", 32'(busy), 32'd1);
    step;
    drive(4'b0000, 16'h0060, 8'h01);
    expect_all("tie_pulse", 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b1, 1'b0, 2'd1);
    step;

    // Reset mid-RUN with requester 1 owning the bus.
    drive(4'b0010, 16'h0060, 8'h01);
    chk("rst_accept ready", 32'(req_ready), 32'b0010);
    step;
    drive(4'b0000, 16'h0060, 8'h02);
    chk("rst_run grant", 32'(grant), 32'b0010);
    rst = 1'b1;
    #1;
    expect_all("rst_mid", 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    step;
    chk("rst_hold done", 32'(done), 32'd0);
    rst = 1'b0;
    drive(4'b1111, 16'h4321, 8'h01);
    chk("rst_after ready", 32'(req_ready), 32'b0001);
    step;
    drive(4'b0000, 16'h4321, 8'h02);
    chk("rst_after grant", 32'(grant), 32'b0001);
    chk("rst_after fsm_cmd", 32'(fsm_cmd), 32'h1);

    // Random traffic against the reference model, starting from a fresh reset.
    rst = 1'b1;
    #1;
    step;
    rst = 1'b0;
    m_owner = -1; m_last = NREQ - 1; m_runcyc = 0; m_id = 0;
    m_left = 1'b0; m_done = 1'b0; m_tmo = 1'b0; m_cmd = 4'h0;
    begin
      bit         stuck = 1'b0;
      logic [7:0] stuck_val = 8'h10;
      for (int n = 0; n < 3000; n++) begin
        logic [3:0]  v;
        logic [15:0] c;
        logic [7:0]  o;
        int          w, r;
        logic [3:0]  e_rdy, e_gnt;
        v = 4'($urandom_range(0, 15));
        c = 16'($urandom);
        if ($urandom_range(0, 63) == 0) begin
          stuck = !stuck;
          stuck_val = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h10;
        end
        r = int'($urandom_range(0, 9));
        if (stuck)       o = stuck_val;
        else if (r < 4)  o = 8'h01;
        else if (r == 9) o = 8'h00;
        else             o = 8'h01 << $urandom_range(1, 7);
        drive(v, c, o);

        w     = (m_owner < 0) ? pick(v, m_last) : -1;
        e_rdy = (w >= 0) ? (4'b0001 << w) : 4'b0000;
        e_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        expect_all($sformatf("rnd%0d", n), e_rdy, e_gnt, (m_owner >= 0) ? m_cmd : 4'h0,
                   m_owner >= 0, m_done, m_tmo, 2'(m_id));

        m_done = 1'b0;
        m_tmo  = 1'b0;
        if (m_owner < 0) begin
          if (w >= 0) begin
            m_owner = w; m_last = w; m_cmd = c[w*4 +: 4];
            m_left = 1'b0; m_runcyc = 0;
          end
        end else begin
          m_runcyc++;
          if (m_left && o == 8'h01) begin
            m_done = 1'b1; m_id = m_owner; m_owner = -1;
          end else if (m_runcyc == TIMEOUT) begin
            m_tmo = 1'b1; m_id = m_owner; m_owner = -1;
          end else if (o != 8'h01) begin
            m_left = 1'b1;
          end
        end
        step;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
